f_ifu: RTL and testbench

F_IFU -- requirements
Module: f_ifu

---
 rtl/f_ifu_pkg.sv | 27 ++
 rtl/f_ifu_if.sv | 33 +++
 rtl/f_npc.sv | 40 ++++
 rtl/f_ifu.sv | 61 ++++++
 tb/tb_f_ifu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/f_ifu_pkg.sv
// +--------------------------------------------------------------+
// | f_ifu_pkg : shared next-PC encodings and fetch constants     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package f_ifu_pkg;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'd0,
      NPC_B   = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_op_e;

   localparam logic [31:0] C_RESET_PC    = 32'h0000_3000;
   localparam logic [31:0] C_NOP         = 32'h0000_0000;
   localparam logic [31:0] C_PC_STEP     = 32'd4;
   localparam logic [31:0] C_LINK_OFFSET = 32'd8;
   localparam logic [1:0]  C_WORD_ALIGN  = 2'b00;
   localparam int          C_IMM16_W     = 16;
   localparam int          C_REGION_HI   = 31;
   localparam int          C_REGION_LO   = 28;

endpackage

`default_nettype wire

// File: rtl/f_ifu_if.sv
// +--------------------------------------------------------------+
// | f_ifu_if : fetch-unit control, IM and F/D register signals   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

interface f_ifu_if;

   logic        stall;
   logic [31:0] F_instr;
   logic [1:0]  NPCop;
   logic        Jump_b;
   logic        FDflush;
   logic [25:0] D_imm26;
   logic [31:0] D_rs;
   logic [31:0] F_PC;
   logic [31:0] D_PC;
   logic [31:0] D_instr;
   logic [31:0] D_PC8;

   modport slave (
      input  stall, F_instr, NPCop, Jump_b, FDflush, D_imm26, D_rs,
      output F_PC, D_PC, D_instr, D_PC8
   );

   modport master (
      output stall, F_instr, NPCop, Jump_b, FDflush, D_imm26, D_rs,
      input  F_PC, D_PC, D_instr, D_PC8
   );

endinterface

`default_nettype wire

// File: rtl/f_npc.sv
// +--------------------------------------------------------------+
// | f_npc : purely combinational next-PC selection               |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module f_npc
   import f_ifu_pkg::*;
(
   input  wire logic [31:0] pc,
   input  wire logic [31:0] d_pc,
   input  wire logic [1:0]  npc_op,
   input  wire logic        jump_b,
   input  wire logic [25:0] imm26,
   input  wire logic [31:0] rs,
   output      logic [31:0] npc
);

   logic [31:0] w_seq_pc;
   logic [31:0] w_branch_off;

   assign w_seq_pc     = pc + C_PC_STEP;
   // Sign-extended word offset: 14 copies of imm16[15] then imm16, then word alignment.
   assign w_branch_off = {{(32 - C_IMM16_W - 2){imm26[C_IMM16_W-1]}},
                          imm26[C_IMM16_W-1:0], C_WORD_ALIGN};

   always_comb begin
      npc = w_seq_pc;
      case (npc_op)
         NPC_PC4: npc = w_seq_pc;
         NPC_B:   npc = jump_b ? (d_pc + C_PC_STEP + w_branch_off) : w_seq_pc;
         NPC_J:   npc = {d_pc[C_REGION_HI:C_REGION_LO], imm26, C_WORD_ALIGN};
         NPC_JR:  npc = rs;
         default: npc = w_seq_pc;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/f_ifu.sv
// +--------------------------------------------------------------+
// | f_ifu : PC register, next-PC steering and F/D pipeline reg   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module f_ifu
   import f_ifu_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  reset,
   f_ifu_if.slave     bus
);

   logic [31:0] pc_q,      pc_d;
   logic [31:0] d_pc_q,    d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic [31:0] w_npc;

   f_npc u_npc (
      .pc     (pc_q),
      .d_pc   (d_pc_q),
      .npc_op (bus.NPCop),
      .jump_b (bus.Jump_b),
      .imm26  (bus.D_imm26),
      .rs     (bus.D_rs),
      .npc    (w_npc)
   );

   // Stall freezes everything; a flush only replaces the word entering D.
   always_comb begin
      pc_d      = pc_q;
      d_pc_d    = d_pc_q;
      d_instr_d = d_instr_q;
      if (!bus.stall) begin
         pc_d      = w_npc;
         d_pc_d    = pc_q;
         d_instr_d = bus.FDflush ? C_NOP : bus.F_instr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= C_RESET_PC;
         d_pc_q    <= C_RESET_PC;
         d_instr_q <= C_NOP;
      end else begin
         pc_q      <= pc_d;
         d_pc_q    <= d_pc_d;
         d_instr_q <= d_instr_d;
      end
   end

   assign bus.F_PC    = pc_q;
   assign bus.D_PC    = d_pc_q;
   assign bus.D_instr = d_instr_q;
   assign bus.D_PC8   = d_pc_q + C_LINK_OFFSET;

endmodule

`default_nettype wire

// File: tb/tb_f_ifu.sv
// +--------------------------------------------------------------+
// | tb_f_ifu : directed + randomized bench for f_ifu             |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_f_ifu;

   logic clk;
   logic reset;
   logic chk_en;
   int   checks;
   int   errors;

   logic [31:0] m_pc, m_dpc, m_dinstr, m_npc;

   f_ifu_if bus ();

   f_ifu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] im(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0C0F_FEE0;
   endfunction

   assign bus.F_instr = im(bus.F_PC);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural fetch behaviour straight from the rules.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc     = 32'h0000_3000;
         m_dpc    = 32'h0000_3000;
         m_dinstr = 32'h0;
      end else if (!bus.stall) begin
         case (bus.NPCop)
            2'd1:    m_npc = bus.Jump_b
                             ? m_dpc + 32'd4 + 32'($signed(bus.D_imm26[15:0])) * 32'd4
                             : m_pc + 32'd4;
            2'd2:    m_npc = (m_dpc & 32'hF000_0000) | ({6'd0, bus.D_imm26} * 32'd4);
            2'd3:    m_npc = bus.D_rs;
            default: m_npc = m_pc + 32'd4;
         endcase
         m_dinstr = bus.FDflush ? 32'h0 : im(m_pc);
         m_dpc    = m_pc;
         m_pc     = m_npc;
      end
   end

   always @(negedge clk) begin
      if (chk_en && reset) begin
         chk("model_F_PC",    bus.F_PC,    m_pc);
         chk("model_D_PC",    bus.D_PC,    m_dpc);
         chk("model_D_instr", bus.D_instr, m_dinstr);
         chk("model_D_PC8",   bus.D_PC8,   m_dpc + 32'd8);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic s, input logic [1:0] op, input logic jb,
                        input logic fl, input logic [25:0] imm, input logic [31:0] rs);
      bus.stall   = s;
      bus.NPCop   = op;
      bus.Jump_b  = jb;
      bus.FDflush = fl;
      bus.D_imm26 = imm;
      bus.D_rs    = rs;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 1'b0, 26'd0, 32'd0);
      reset = 1'b1;
      #1 reset = 1'b0;
      cyc();
      cyc();
      chk("rst_F_PC",    bus.F_PC,    32'h0000_3000);
      chk("rst_D_PC",    bus.D_PC,    32'h0000_3000);
      chk("rst_D_instr", bus.D_instr, 32'h0);
      reset  = 1'b1;
      chk_en = 1'b1;

      // Reset release: sequential fetch.
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk("rel_F_PC",    bus.F_PC,    32'h0000_3000 + 32'(4 * k));
         chk("rel_D_instr", bus.D_instr, im(32'h0000_3000 + 32'(4 * (k - 1))));
      end
      cyc();
      cyc();
      chk("pre_br_D_PC", bus.D_PC, 32'h0000_3010);

      // Taken backward branch with delay slot.
      drive(1'b0, 2'd1, 1'b1, 1'b0, 26'h000FFFC, 32'd0);
      cyc();
      chk("br_F_PC",    bus.F_PC,    32'h0000_3004);
      chk("br_D_PC",    bus.D_PC,    32'h0000_3014);
      chk("br_D_instr", bus.D_instr, im(32'h0000_3014));

      // Likely branch not taken: delay slot squashed.
      drive(1'b0, 2'd1, 1'b0, 1'b1, 26'h000FFFC, 32'd0);
      cyc();
      chk("sq_D_instr", bus.D_instr, 32'h0);
      chk("sq_D_PC",    bus.D_PC,    32'h0000_3004);
      chk("sq_F_PC",    bus.F_PC,    32'h0000_3008);

      drive(1'b0, 2'd0, 1'b0, 1'b0, 26'd0, 32'd0);
      cyc();
      // Stall dominates flush and control transfer.
      drive(1'b1, 2'd2, 1'b1, 1'b1, 26'h0000C10, 32'h1234_5678);
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("st_F_PC",    bus.F_PC,    32'h0000_300C);
         chk("st_D_PC",    bus.D_PC,    32'h0000_3008);
         chk("st_D_instr", bus.D_instr, im(32'h0000_3008));
      end
      drive(1'b0, 2'd0, 1'b0, 1'b1, 26'd0, 32'd0);
      cyc();
      chk("stf_F_PC",    bus.F_PC,    32'h0000_3010);
      chk("stf_D_PC",    bus.D_PC,    32'h0000_300C);
      chk("stf_D_instr", bus.D_instr, 32'h0);

      // Jump and register jump.
      drive(1'b0, 2'd3, 1'b0, 1'b0, 26'd0, 32'h0000_301C);
      cyc();
      drive(1'b0, 2'd0, 1'b0, 1'b0, 26'd0, 32'd0);
      cyc();
      cyc();
      chk("j_pre_D_PC", bus.D_PC, 32'h0000_3020);
      drive(1'b0, 2'd2, 1'b0, 1'b0, 26'h0000C10, 32'd0);
      cyc();
      chk("j_F_PC", bus.F_PC, 32'h0000_3040);
      drive(1'b0, 2'd3, 1'b0, 1'b0, 26'd0, 32'h0000_3001);
      cyc();
      chk("jr_F_PC", bus.F_PC, 32'h0000_3001);

      // Wrap at the top of the address space.
      drive(1'b0, 2'd3, 1'b0, 1'b0, 26'd0, 32'hFFFF_FFFC);
      cyc();
      drive(1'b0, 2'd0, 1'b0, 1'b0, 26'd0, 32'd0);
      cyc();
      chk("wrap_F_PC", bus.F_PC, 32'h0);
      chk("wrap_D_PC8", bus.D_PC8, 32'h0000_0004);

      // Async reset between edges.
      reset = 1'b0;
      #1;
      chk("ar_F_PC",    bus.F_PC,    32'h0000_3000);
      chk("ar_D_PC",    bus.D_PC,    32'h0000_3000);
      chk("ar_D_instr", bus.D_instr, 32'h0);
      #1 reset = 1'b1;
      cyc();
      chk("ar_rel_F_PC", bus.F_PC, 32'h0000_3004);

      // Randomized traffic, with occasional reset mid-stall or mid-branch.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(3) == 0), 2'($urandom_range(3)), 1'($urandom),
               ($urandom_range(7) == 0), 26'($urandom),
               ($urandom_range(1) == 0) ? 32'($urandom) : 32'h0000_3000 + 32'($urandom_range(255) * 4));
         if ($urandom_range(39) == 0) begin
            reset = 1'b0;
            #1 reset = 1'b1;
         end
         cyc();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
